// File: rtl/audio_sample_fetch_master_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_fetch_master_if
// Brief    : Avalon-MM read-master bus bundle for the audio sample fetcher.
// Revision : 1.0
// ============================================================================
interface audio_sample_fetch_master_if;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_lock;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    modport master (
        output m_address,
        output m_read,
        output m_lock,
        input  m_waitrequest,
        input  m_readdata,
        input  m_readdatavalid
    );

    modport slave (
        input  m_address,
        input  m_read,
        input  m_lock,
        output m_waitrequest,
        output m_readdata,
        output m_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/audio_sample_fetch_master.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_fetch_master
// Brief    : Pipelined Avalon-MM word fetcher feeding stereo samples to a codec.
// Revision : 1.0
// ============================================================================
module audio_sample_fetch_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 24
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    input  wire logic                    start,
    input  wire logic                    stop,
    input  wire logic [31:0]             base_addr,
    input  wire logic [LEN_W-1:0]        length_words,
    input  wire logic                    loop,
    output logic                         busy,
    output logic                         done,
    output logic                         underrun,
    audio_sample_fetch_master_if.master  m_bus,
    input  wire logic                    sample_req,
    output logic [15:0]                  left_sample,
    output logic [15:0]                  right_sample,
    output logic                         sample_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        base_q, base_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               loop_q, loop_d;
    logic               stop_pend_q, stop_pend_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic               done_q, done_d;
    logic               underrun_q, underrun_d;
    logic [15:0]        left_q, left_d;
    logic [15:0]        right_q, right_d;
    logic               sample_valid_q, sample_valid_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [31:0]        fifo_mem_q [FIFO_DEPTH];

    logic [CW:0]        inflight_level;
    logic               credit;
    logic               rd_cmd;
    logic               accept;
    logic               stalled;
    logic               resp;
    logic               push;
    logic               pop;
    logic               flush;
    logic               clr_underrun;

    // Words already buffered plus words still in flight must fit the FIFO.
    assign inflight_level = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit         = inflight_level < (CW+1)'(FIFO_DEPTH);
    assign rd_cmd         = (state_q == S_FETCH) && (remaining_q != '0) && credit;
    assign accept         = rd_cmd && !m_bus.m_waitrequest;
    assign stalled        = rd_cmd && m_bus.m_waitrequest;
    assign resp           = m_bus.m_readdatavalid && (outstanding_q != '0) && (state_q != S_IDLE);
    assign push           = resp && (state_q == S_FETCH);
    assign pop            = sample_req && (count_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, resp})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        base_d       = base_q;
        length_d     = length_q;
        remaining_d  = remaining_q;
        loop_d       = loop_q;
        stop_pend_d  = stop_pend_q;
        done_d       = 1'b0;
        flush        = 1'b0;
        clr_underrun = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (length_words != '0) begin
                        base_d       = base_addr & ~32'd3;
                        addr_d       = base_addr & ~32'd3;
                        length_d     = length_words;
                        remaining_d  = length_words;
                        loop_d       = loop;
                        stop_pend_d  = 1'b0;
                        flush        = 1'b1;
                        clr_underrun = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (accept) begin
                    if ((remaining_q == LEN_W'(1)) && loop_q) begin
                        addr_d      = base_q;
                        remaining_d = length_q;
                    end else begin
                        addr_d      = addr_q + 32'd4;
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                end
                // A stalled command must complete before the abort takes effect.
                if (stop || stop_pend_q) begin
                    if (stalled) begin
                        stop_pend_d = 1'b1;
                    end else begin
                        stop_pend_d = 1'b0;
                        state_d     = S_DRAIN;
                    end
                end else if ((remaining_q == '0) && (outstanding_d == '0)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q + AW'(push);
        rd_ptr_d       = rd_ptr_q + AW'(pop);
        count_d        = count_q + CW'(push) - CW'(pop);
        left_d         = left_q;
        right_d        = right_q;
        sample_valid_d = 1'b0;
        underrun_d     = clr_underrun ? 1'b0 : underrun_q;

        if (pop) begin
            left_d         = fifo_mem_q[rd_ptr_q][31:16];
            right_d        = fifo_mem_q[rd_ptr_q][15:0];
            sample_valid_d = 1'b1;
        end
        if (sample_req && (count_q == '0)) begin
            underrun_d = 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            base_q         <= '0;
            length_q       <= '0;
            remaining_q    <= '0;
            loop_q         <= 1'b0;
            stop_pend_q    <= 1'b0;
            outstanding_q  <= '0;
            done_q         <= 1'b0;
            underrun_q     <= 1'b0;
            left_q         <= '0;
            right_q        <= '0;
            sample_valid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            base_q         <= base_d;
            length_q       <= length_d;
            remaining_q    <= remaining_d;
            loop_q         <= loop_d;
            stop_pend_q    <= stop_pend_d;
            outstanding_q  <= outstanding_d;
            done_q         <= done_d;
            underrun_q     <= underrun_d;
            left_q         <= left_d;
            right_q        <= right_d;
            sample_valid_q <= sample_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Storage array carries no reset; occupancy is governed by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= m_bus.m_readdata;
        end
    end

    assign m_bus.m_address = addr_q;
    assign m_bus.m_read    = rd_cmd;
    assign m_bus.m_lock    = 1'b0;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign underrun        = underrun_q;
    assign left_sample     = left_q;
    assign right_sample    = right_q;
    assign sample_valid    = sample_valid_q;
endmodule
`default_nettype wire
